// File: rtl/iir_sos_cascade_fp.sv
// Multi-channel cascade of second-order IIR sections on one time-shared 18-bit FP MAC.
// Define IIR_COEF_SHADOW_EN for a double-buffered coefficient bank swapped at pass start.
module iir_sos_cascade_fp #(
  parameter int NUM_SOS = 2,
  parameter int NUM_CH  = 2,
  parameter int CA_W    = $clog2(5*NUM_SOS+1)
) (
  input  logic                   state_clk,
  input  logic                   reset,
  input  logic                   lr_clk,
  input  logic [16*NUM_CH-1:0]   audio_in,
  output logic [16*NUM_CH-1:0]   audio_out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   coef_we,
  input  logic [CA_W-1:0]        coef_addr,
  input  logic [17:0]            coef_wdata,
  input  logic                   coef_commit
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW  = (NUM_SOS > 1) ? $clog2(NUM_SOS) : 1;
  localparam int NCH2 = 1 << CHW;
  localparam int NS2  = 1 << SW;
  localparam int NCO2 = 1 << CA_W;
  localparam logic [CA_W-1:0] GAIN_IDX = CA_W'(5*NUM_SOS);
  localparam logic [3:0] IDLE = 4'd0, LOAD = 4'd1, MAC0 = 4'd2, MAC1 = 4'd3, MAC2 = 4'd4,
                         MAC3 = 4'd5, MAC4 = 4'd6, UPD = 4'd7, GAIN = 4'd8, STORE = 4'd9,
                         DONE = 4'd10;

  function automatic logic [17:0] fp_mul(input logic [17:0] a, input logic [17:0] b);
    logic [17:0] p;
    logic [8:0] m;
    logic signed [10:0] e;
    p = {9'b0, a[8:0]} * {9'b0, b[8:0]};
    e = $signed({3'b0, a[16:9]}) + $signed({3'b0, b[16:9]}) - 11'sd128;
    if (p[17]) m = p[17:9];
    else begin
      m = p[16:8];
      e = e - 11'sd1;
    end
    if (!a[8] || !b[8] || e < 0) return 18'h0;
    if (e > 11'sd255) return {a[17] ^ b[17], 8'hFF, 9'h1FF};
    return {a[17] ^ b[17], e[7:0], m};
  endfunction

  function automatic logic [17:0] fp_add(input logic [17:0] a, input logic [17:0] b);
    logic [17:0] hi, lo;
    logic [7:0] d;
    logic [8:0] ls, dif;
    logic [9:0] sum;
    logic signed [9:0] e;
    int p;
    if (!a[8]) return b;
    if (!b[8]) return a;
    if (a[16:0] >= b[16:0]) begin hi = a; lo = b; end
    else begin hi = b; lo = a; end
    d  = hi[16:9] - lo[16:9];
    ls = (d > 8'd9) ? 9'd0 : (lo[8:0] >> d);
    if (hi[17] == lo[17]) begin
      sum = {1'b0, hi[8:0]} + {1'b0, ls};
      if (!sum[9]) return {hi[17], hi[16:9], sum[8:0]};
      if (hi[16:9] == 8'hFF) return {hi[17], 8'hFF, 9'h1FF};
      return {hi[17], hi[16:9] + 8'd1, sum[9:1]};
    end
    dif = hi[8:0] - ls;
    if (dif == 9'd0) return 18'h0;
    p = 0;
    for (int i = 0; i < 9; i++) if (dif[i]) p = i;
    e = $signed({2'b0, hi[16:9]}) - 10'(8 - p);
    if (e < 0) return 18'h0;
    return {hi[17], e[7:0], dif << (8 - p)};
  endfunction

  function automatic logic [17:0] int2fp(input logic [9:0] v);
    logic [9:0] mag;
    logic [18:0] t;
    int p;
    mag = v[9] ? (~v + 10'd1) : v;
    if (mag == 10'd0) return 18'h0;
    p = 0;
    for (int i = 0; i < 10; i++) if (mag[i]) p = i;
    t = {mag, 9'b0} >> (p + 1);
    return {v[9], 8'(129 + p), t[8:0]};
  endfunction

  // Truncate toward zero; anything of magnitude >= 512 clamps to the 10-bit rails.
  function automatic logic [9:0] fp2int(input logic [17:0] a);
    logic [9:0] mag;
    int sh;
    if (!a[8]) return 10'd0;
    sh = int'(a[16:9]) - 137;
    if (sh > 0) mag = a[17] ? 10'd512 : 10'd511;
    else        mag = {1'b0, a[8:0] >> (-sh)};
    return a[17] ? (~mag + 10'd1) : mag;
  endfunction

  logic [3:0]                state;
  logic                      lr_d;
  logic [CHW-1:0]            ch;
  logic [SW-1:0]             sec;
  logic [CA_W-1:0]           cptr;
  logic [NUM_CH-1:0][9:0]    samp;
  logic [NUM_CH-1:0][15:0]   stage, nstage, out_r;
  logic [17:0]               xin, acc, cval, opnd, prod, sum;
  logic [17:0]               x1 [NCH2][NS2];
  logic [17:0]               x2 [NCH2][NS2];
  logic [17:0]               y1 [NCH2][NS2];
  logic [17:0]               y2 [NCH2][NS2];
  logic [17:0]               coef [NCO2];
  logic                      start;

  assign start     = (state == IDLE) && lr_clk && !lr_d;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign audio_out = out_r;

  always_comb begin
    cval = coef[cptr];
    case (state)
      MAC1:    opnd = x1[ch][sec];
      MAC2:    opnd = x2[ch][sec];
      MAC3:    opnd = y1[ch][sec];
      MAC4:    opnd = y2[ch][sec];
      default: opnd = xin;
    endcase
    prod = fp_mul(cval, opnd);
    sum  = fp_add(acc, prod);
    nstage     = stage;
    nstage[ch] = {fp2int(acc), 6'b0};
  end

  always_ff @(posedge state_clk) begin
    if (reset) begin
      state <= IDLE;
      lr_d  <= 1'b1;
      overrun <= 1'b0;
      out_r <= '0;
      stage <= '0;
      samp  <= '0;
      ch    <= '0;
      sec   <= '0;
      cptr  <= '0;
      xin   <= '0;
      acc   <= '0;
      for (int i = 0; i < NCH2; i++)
        for (int j = 0; j < NS2; j++) begin
          x1[i][j] <= '0; x2[i][j] <= '0; y1[i][j] <= '0; y2[i][j] <= '0;
        end
    end else begin
      lr_d <= lr_clk;
      if (lr_clk && !lr_d && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (start) begin
          for (int c = 0; c < NUM_CH; c++) samp[c] <= audio_in[16*c+6 +: 10];
          ch    <= '0;
          state <= LOAD;
        end
        LOAD: begin
          xin   <= int2fp(samp[ch]);
          sec   <= '0;
          cptr  <= '0;
          state <= MAC0;
        end
        MAC0, MAC1, MAC2, MAC3, MAC4: begin
          acc   <= (state == MAC0) ? prod : sum;
          cptr  <= cptr + CA_W'(1);
          state <= state + 4'd1;
        end
        UPD: begin
          y1[ch][sec] <= acc;
          y2[ch][sec] <= y1[ch][sec];
          x1[ch][sec] <= xin;
          x2[ch][sec] <= x1[ch][sec];
          xin <= acc;
          if (sec == SW'(NUM_SOS - 1)) state <= GAIN;
          else begin
            sec   <= sec + SW'(1);
            state <= MAC0;
          end
        end
        GAIN: begin
          acc   <= prod;
          state <= STORE;
        end
        // Slots are staged so every channel of audio_out changes in the same cycle.
        STORE: begin
          stage <= nstage;
          if (ch == CHW'(NUM_CH - 1)) begin
            out_r <= nstage;
            state <= DONE;
          end else begin
            ch    <= ch + CHW'(1);
            state <= LOAD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IIR_COEF_SHADOW_EN
  logic [17:0] shadow [NCO2];
  logic        pend;

  always_ff @(posedge state_clk)
    if (coef_we && coef_addr <= GAIN_IDX) shadow[coef_addr] <= coef_wdata;

  always_ff @(posedge state_clk)
    if (!reset && start && pend)
      for (int k = 0; k < NCO2; k++) coef[k] <= shadow[k];

  always_ff @(posedge state_clk) begin
    if (reset)            pend <= 1'b0;
    else if (coef_commit) pend <= 1'b1;
    else if (start)       pend <= 1'b0;
  end
`else
  logic unused_commit;
  assign unused_commit = coef_commit;

  // Coefficients are deliberately outside reset so they survive a mid-stream reset.
  always_ff @(posedge state_clk)
    if (coef_we && coef_addr <= GAIN_IDX) coef[coef_addr] <= coef_wdata;
`endif

endmodule
